// File: rtl/rv_wb_pkg.sv
// Shared types and helpers for the writeback arbiter and its load FIFO.
package rv_wb_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int NUM_REGS = 32;

    // One buffered load result; kill marks an entry superseded by a younger ALU write.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
        logic              kill;
    } wb_entry_t;

    // One-hot destination mask; x0 is never reported as pending.
    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_AW-1:0] rd);
        logic [NUM_REGS-1:0] m;
        m     = '0;
        m[rd] = 1'b1;
        m[0]  = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Load-result buffer: circular FIFO with wrap-bit pointers, per-entry kill by
// destination register, and a live-destination mask for hazard tracking.
// Entries written to x0 are stored already killed so they drain without a write.
module wb_load_fifo
    import rv_wb_pkg::*;
#(
    parameter int LD_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_push,
    input  logic [REG_AW-1:0]   i_push_rd,
    input  logic [XLEN-1:0]     i_push_data,
    input  logic                i_pop,
    input  logic                i_kill_valid,
    input  logic [REG_AW-1:0]   i_kill_rd,
    output logic [REG_AW-1:0]   o_head_rd,
    output logic [XLEN-1:0]     o_head_data,
    output logic                o_head_kill,
    output logic                o_empty,
    output logic                o_full,
    output logic [NUM_REGS-1:0] o_live_mask
);

    localparam int PW = $clog2(LD_DEPTH);
    localparam logic [PW:0] PTR_ONE = 1;

    logic [PW:0]          r_wr_ptr;
    logic [PW:0]          r_rd_ptr;
    wb_entry_t            r_mem [LD_DEPTH];
    logic [LD_DEPTH-1:0]  r_valid;

    logic [PW-1:0]        w_wr_idx;
    logic [PW-1:0]        w_rd_idx;
    logic                 w_push;
    logic                 w_pop;
    logic [NUM_REGS-1:0]  w_live_mask;

    assign w_wr_idx = r_wr_ptr[PW-1:0];
    assign w_rd_idx = r_rd_ptr[PW-1:0];
    assign o_empty  = (r_wr_ptr == r_rd_ptr);
    assign o_full   = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (w_wr_idx == w_rd_idx);
    assign w_push   = i_push && !o_full;
    assign w_pop    = i_pop && !o_empty;

    // Storage, pointers and kill marking; the slot being pushed is not yet valid,
    // so a same-cycle kill never reaches the incoming (younger) entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_valid  <= '0;
            for (int i = 0; i < LD_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LD_DEPTH; i++) begin
                if (r_valid[i] && i_kill_valid && (r_mem[i].rd == i_kill_rd)) begin
                    r_mem[i].kill <= 1'b1;
                end
            end
            if (w_pop) begin
                r_valid[w_rd_idx] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + PTR_ONE;
            end
            if (w_push) begin
                r_mem[w_wr_idx]   <= '{rd: i_push_rd, data: i_push_data, kill: (i_push_rd == '0)};
                r_valid[w_wr_idx] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + PTR_ONE;
            end
        end
    end

    // Destinations still owed a write by the FIFO.
    always_comb begin
        w_live_mask = '0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            if (r_valid[i] && !r_mem[i].kill) begin
                w_live_mask = w_live_mask | rd_onehot(r_mem[i].rd);
            end
        end
    end

    assign o_live_mask = w_live_mask;
    assign o_head_rd   = r_mem[w_rd_idx].rd;
    assign o_head_data = r_mem[w_rd_idx].data;
    assign o_head_kill = r_mem[w_rd_idx].kill;

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Writeback arbiter: merges ALU and buffered load results onto the single
// register-file write port, with anti-starvation for loads and WAW kill.
// Optional macro WB_FWD_EN adds a combinational bypass of the write stage.
module rf_writeback_arbiter
    import rv_wb_pkg::*;
#(
    parameter int LD_DEPTH  = 4,
    parameter int STALL_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [REG_AW-1:0]   alu_rd,
    input  logic [XLEN-1:0]     alu_data,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [REG_AW-1:0]   ld_rd,
    input  logic [XLEN-1:0]     ld_data,
`ifdef WB_FWD_EN
    input  logic [REG_AW-1:0]   fwd_rs1,
    input  logic [REG_AW-1:0]   fwd_rs2,
    output logic                fwd_hit1,
    output logic                fwd_hit2,
    output logic [XLEN-1:0]     fwd_data1,
    output logic [XLEN-1:0]     fwd_data2,
`endif
    output logic [REG_AW-1:0]   Write_Register,
    output logic [XLEN-1:0]     Write_Data,
    output logic                Write_Enable,
    output logic [NUM_REGS-1:0] busy_mask
);

    localparam int SW = $clog2(STALL_MAX + 1);
    localparam logic [SW-1:0] STALL_TOP = SW'(STALL_MAX);
    localparam logic [SW-1:0] STALL_ONE = 1;

    logic [SW-1:0]        r_stall_cnt;
    logic                 r_we;
    logic [REG_AW-1:0]    r_wr;
    logic [XLEN-1:0]      r_wd;

    logic [REG_AW-1:0]    w_head_rd;
    logic [XLEN-1:0]      w_head_data;
    logic                 w_head_kill;
    logic                 w_empty;
    logic                 w_full;
    logic [NUM_REGS-1:0]  w_live_mask;
    logic                 w_force;
    logic                 w_force_drain;
    logic                 w_alu_issue;
    logic                 w_head_issue;
    logic                 w_push;
    logic                 w_kill_valid;

    // Full is the registered FIFO state, so a push is refused even if the head pops this cycle.
    assign ld_ready      = !w_full;
    assign w_push        = ld_valid && !w_full;
    assign w_force       = w_full || (r_stall_cnt == STALL_TOP);
    assign w_force_drain = w_force && !w_empty;
    assign alu_ready     = !w_force_drain;
    assign w_alu_issue   = alu_valid && !w_force_drain;
    assign w_head_issue  = !w_empty && (w_force || !alu_valid);
    assign w_kill_valid  = w_alu_issue && (alu_rd != '0);

    wb_load_fifo #(
        .LD_DEPTH (LD_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_rd    (ld_rd),
        .i_push_data  (ld_data),
        .i_pop        (w_head_issue),
        .i_kill_valid (w_kill_valid),
        .i_kill_rd    (alu_rd),
        .o_head_rd    (w_head_rd),
        .o_head_data  (w_head_data),
        .o_head_kill  (w_head_kill),
        .o_empty      (w_empty),
        .o_full       (w_full),
        .o_live_mask  (w_live_mask)
    );

    // Count cycles a waiting load head loses arbitration; saturates at the force threshold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_empty || w_head_issue) begin
            r_stall_cnt <= '0;
        end else if (r_stall_cnt != STALL_TOP) begin
            r_stall_cnt <= r_stall_cnt + STALL_ONE;
        end
    end

    // Registered write port; x0 targets and killed loads complete without a strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we <= 1'b0;
            r_wr <= '0;
            r_wd <= '0;
        end else if (w_alu_issue) begin
            r_we <= (alu_rd != '0);
            if (alu_rd != '0) begin
                r_wr <= alu_rd;
                r_wd <= alu_data;
            end
        end else if (w_head_issue) begin
            r_we <= !w_head_kill;
            if (!w_head_kill) begin
                r_wr <= w_head_rd;
                r_wd <= w_head_data;
            end
        end else begin
            r_we <= 1'b0;
        end
    end

    assign Write_Enable   = r_we;
    assign Write_Register = r_wr;
    assign Write_Data     = r_wd;
    assign busy_mask      = w_live_mask | (r_we ? rd_onehot(r_wr) : '0);

`ifdef WB_FWD_EN
    // The RF sees this write only at the next edge, so decode reads take it from here.
    assign fwd_hit1  = r_we && (r_wr == fwd_rs1) && (fwd_rs1 != '0);
    assign fwd_hit2  = r_we && (r_wr == fwd_rs2) && (fwd_rs2 != '0);
    assign fwd_data1 = r_wd;
    assign fwd_data2 = r_wd;
`endif

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed testbench for rf_writeback_arbiter (optionally built with WB_FWD_EN).
module tb_rf_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [4:0]  Write_Register;
    logic [31:0] Write_Data;
    logic        Write_Enable;
    logic [31:0] busy_mask;
`ifdef WB_FWD_EN
    logic [4:0]  fwd_rs1 = '0;
    logic [4:0]  fwd_rs2 = '0;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data1;
    logic [31:0] fwd_data2;
`endif

    int n_chk = 0;
    int n_err = 0;

    rf_writeback_arbiter #(.LD_DEPTH(4), .STALL_MAX(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_rd          (ld_rd),
        .ld_data        (ld_data),
`ifdef WB_FWD_EN
        .fwd_rs1        (fwd_rs1),
        .fwd_rs2        (fwd_rs2),
        .fwd_hit1       (fwd_hit1),
        .fwd_hit2       (fwd_hit2),
        .fwd_data1      (fwd_data1),
        .fwd_data2      (fwd_data2),
`endif
        .Write_Register (Write_Register),
        .Write_Data     (Write_Data),
        .Write_Enable   (Write_Enable),
        .busy_mask      (busy_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldd);
        alu_valid = av;
        alu_rd    = ard;
        alu_data  = ad;
        ld_valid  = lv;
        ld_rd     = lrd;
        ld_data   = ldd;
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic we, input logic [4:0] wr, input logic [31:0] wd);
        chk({tag, "_we"}, 32'(Write_Enable), 32'(we));
        chk({tag, "_wr"}, 32'(Write_Register), 32'(wr));
        chk({tag, "_wd"}, Write_Data, wd);
    endtask

    initial begin
        // Power-on reset
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk_wr("por", 1'b0, 5'd0, 32'h0);
        chk("por_busy", busy_mask, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("por_alu_ready", 32'(alu_ready), 32'd1);
        chk("por_ld_ready", 32'(ld_ready), 32'd1);

        // ALU only
        drive(1, 5'd5, 32'h1234, 0, 0, 0);
        chk("alu_ready", 32'(alu_ready), 32'd1);
        tick();
        chk_wr("alu", 1'b1, 5'd5, 32'h1234);
        chk("alu_busy", busy_mask, 32'h20);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("alu_pulse_end", 32'(Write_Enable), 32'd0);
        chk("alu_busy_clr", busy_mask, 32'h0);

        // Starvation: load rd=7 loses four cycles to ALU rd=2, then is forced
        drive(1, 5'd2, 32'h22, 1, 5'd7, 32'h77);
        chk("stv_ld_ready", 32'(ld_ready), 32'd1);
        tick();
        chk_wr("stv_e0", 1'b1, 5'd2, 32'h22);
        chk("stv_busy", busy_mask, 32'h84);
        drive(1, 5'd2, 32'h22, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            chk("stv_alu_ready", 32'(alu_ready), 32'd1);
            tick();
            chk("stv_alu_wr", 32'(Write_Register), 32'd2);
        end
        chk("stv_forced_alu_ready", 32'(alu_ready), 32'd0);
        tick();
        chk_wr("stv_load", 1'b1, 5'd7, 32'h77);
        chk("stv_resume_ready", 32'(alu_ready), 32'd1);
        tick();
        chk_wr("stv_resume", 1'b1, 5'd2, 32'h22);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("stv_idle", 32'(Write_Enable), 32'd0);

        // Full: four loads queued behind a busy ALU
        drive(1, 5'd2, 32'h2, 1, 5'd10, 32'hA10);
        tick();
        drive(1, 5'd2, 32'h2, 1, 5'd11, 32'hA11);
        tick();
        drive(1, 5'd2, 32'h2, 1, 5'd12, 32'hA12);
        tick();
        drive(1, 5'd2, 32'h2, 1, 5'd13, 32'hA13);
        tick();
        drive(1, 5'd2, 32'h2, 1, 5'd14, 32'hA14);
        chk("full_ld_ready", 32'(ld_ready), 32'd0);
        chk("full_alu_ready", 32'(alu_ready), 32'd0);
        chk("full_busy", busy_mask, 32'h3C04);
        tick();
        chk_wr("full_drain", 1'b1, 5'd10, 32'hA10);
        drive(1, 5'd2, 32'h2, 0, 0, 0);
        chk("full_ld_ready_back", 32'(ld_ready), 32'd1);
        chk("full_alu_ready_back", 32'(alu_ready), 32'd1);
        tick();
        chk("full_alu_wr", 32'(Write_Register), 32'd2);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk_wr("full_d11", 1'b1, 5'd11, 32'hA11);
        tick();
        chk_wr("full_d12", 1'b1, 5'd12, 32'hA12);
        tick();
        chk_wr("full_d13", 1'b1, 5'd13, 32'hA13);
        tick();
        chk("full_empty_we", 32'(Write_Enable), 32'd0);
        chk("full_empty_busy", busy_mask, 32'h0);

        // WAW kill: queued load rd=3 superseded by ALU rd=3
        drive(1, 5'd2, 32'h2, 1, 5'd3, 32'h33);
        tick();
        drive(1, 5'd3, 32'hA, 0, 0, 0);
        chk("waw_busy_pre", busy_mask, 32'hC);
        chk("waw_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        chk_wr("waw_alu", 1'b1, 5'd3, 32'hA);
        chk("waw_busy_out", busy_mask, 32'h8);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("waw_killed_pop", 32'(Write_Enable), 32'd0);
        chk("waw_busy_clr", busy_mask, 32'h0);
        tick();
        chk("waw_quiet", 32'(Write_Enable), 32'd0);

        // Same-cycle load enqueue and ALU write to rd=4: load is younger and still lands
        drive(1, 5'd4, 32'h44A, 1, 5'd4, 32'h44B);
        tick();
        chk_wr("same_alu", 1'b1, 5'd4, 32'h44A);
        chk("same_busy", busy_mask, 32'h10);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk_wr("same_load", 1'b1, 5'd4, 32'h44B);
        tick();
        chk("same_idle", 32'(Write_Enable), 32'd0);

        // rd=0 from both sources
        drive(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF);
        chk("x0_alu_ready", 32'(alu_ready), 32'd1);
        tick();
        chk("x0_alu_we", 32'(Write_Enable), 32'd0);
        chk("x0_busy", busy_mask, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("x0_ld_we", 32'(Write_Enable), 32'd0);
        chk("x0_busy2", busy_mask, 32'h0);
        tick();
        chk("x0_quiet", 32'(Write_Enable), 32'd0);

`ifdef WB_FWD_EN
        drive(1, 5'd9, 32'h99, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        fwd_rs1 = 5'd9;
        fwd_rs2 = 5'd8;
        #1;
        chk("fwd_hit1", 32'(fwd_hit1), 32'd1);
        chk("fwd_data1", fwd_data1, 32'h99);
        chk("fwd_hit2", 32'(fwd_hit2), 32'd0);
        tick();
        chk("fwd_hit1_end", 32'(fwd_hit1), 32'd0);
        fwd_rs1 = 5'd0;
        fwd_rs2 = 5'd0;
`endif

        // Reset mid-stream discards queued loads
        drive(1, 5'd2, 32'h22, 1, 5'd20, 32'h20);
        tick();
        drive(1, 5'd2, 32'h22, 1, 5'd21, 32'h21);
        tick();
        chk("mid_busy_pre", busy_mask, 32'h300004);
        #2;
        rst_n = 1'b0;
        #1;
        chk_wr("mid_rst", 1'b0, 5'd0, 32'h0);
        chk("mid_rst_busy", busy_mask, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mid_alu_ready", 32'(alu_ready), 32'd1);
        chk("mid_ld_ready", 32'(ld_ready), 32'd1);
        tick();
        chk("mid_no_write1", 32'(Write_Enable), 32'd0);
        tick();
        chk("mid_no_write2", 32'(Write_Enable), 32'd0);
        chk("mid_busy_post", busy_mask, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
